snail_match_logger: RTL and testbench
=====================================

# snail_match_logger

Downstream consumer of the 1101 snail-pattern Moore detector. Takes the detector's one-cycle `y` pulse and counts matches. For each match it measures the distance in clock cycles since the previous match. Each match becomes a {first, gap} record in a small FIFO, drained by a valid/ready consumer such as a CPU-visible register block or trace buffer.

## Interface
- `GAP_W`, 8: width of the gap field and distance counter; saturates at 2^GAP_W-1.
- `CNT_W`, 16: width of the total match counter; saturates at 2^CNT_W-1.
- `DEPTH`, 4: FIFO depth in records; power of two, ≥2.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset; asserting low clears all state immediately.
- `match` in 1: detector `y`, sampled each rising edge; high = one match this cycle.
- `clear` in 1: synchronous clear, same effect as reset.
- `rec_valid` out 1: head record present.
- `rec_ready` in 1: consumer accepts head record when `rec_valid` is high.
- `rec_first` out 1: head record is the first match since reset/clear.
- `rec_gap` out GAP_W: head record distance; 0 when `rec_first`=1.
- `match_count` out CNT_W: total matches since reset/clear, including dropped ones.
- `overflow` out 1: sticky; a record was dropped because the FIFO was full.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Reset state: `rec_valid`=0, `rec_first`=0, `rec_gap`=0, `match_count`=0, `overflow`=0, `level`=0.
- Internal state after reset: distance counter `dist`=0 and the `armed` flag set to 1.
- Distance counter:
  - On a match cycle, `dist` loads 1.
  - Otherwise it increments, saturating at 2^GAP_W-1.
  - Consequence: matches at cycles t and t+k give gap = min(k, 2^GAP_W-1).
- Record formation on a match cycle:
  - If `armed`=1: the record is {first=1, gap=0} and `armed` clears.
  - Otherwise: the record is {first=0, gap=`dist`}.
- `match_count` increments on every match cycle, saturating. It increments whether or not the record is stored.
- Push on match:
  - Push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Full with no pop: the record is dropped, `overflow` sets, and FIFO contents are unchanged.
- Pop: when `rec_valid` && `rec_ready`, the head is removed.
- FIFO is a circular buffer with wrap-around read/write pointers. `level` = push − pop each cycle; push and pop in the same cycle leaves `level` unchanged.
- Head outputs come directly from FIFO storage at the read pointer. They are stable while `rec_valid`=1 and `rec_ready`=0.
- `rec_first`/`rec_gap` are don't-care when `rec_valid`=0, but are driven to 0 on reset.
- `clear` effect:
  - Empties the FIFO and zeroes `match_count`, `overflow` and `dist`.
  - Re-arms `armed`.
  - Has priority over `match` and pop in the same cycle; those events are discarded.
- Reset asserted mid-operation: all pending records are lost and there is no partial state. After release the block behaves as from power-up.

## Timing
- Match-to-visible latency is 1 cycle: a match sampled at edge N gives `rec_valid`=1 after edge N if the FIFO was empty.
- `match_count` and `overflow` update at the same edge as the match.
- Pop takes effect at the accepting edge. The next head, if any, is presented in the following cycle with no bubble.
- With a continuous `rec_ready`=1 and gaps ≥1, throughput is one record per cycle and the FIFO never fills.
- Minimum legal gap from a 1101 detector is 3 (e.g. overlapping 1101101). The block itself accepts any gap ≥1, including back-to-back pulses.
- Reset release is synchronous to the design only through `clk`. The first edge after deassertion may sample `match`.

## Test plan
- Reset, then `match` pulses at cycles 10, 13, 20 with `rec_ready`=1 → records {1,0}, {0,3}, {0,7}; `match_count`=3; `overflow`=0.
- `rec_ready`=0, DEPTH=4, 6 matches spaced 3 cycles apart → `level`=4, `overflow`=1, `match_count`=6. Then raising `rec_ready` drains exactly the first 4 records (gaps 0,3,3,3) in 4 consecutive cycles.
- Gap saturation with GAP_W=8: matches 300 cycles apart → second record gap=255.
- FIFO full with `match` and pop in the same cycle → no drop, `level` stays 4, `overflow` stays 0, and the new record appears at the tail.
- `clear` asserted in the same cycle as `match` with 2 records queued → `level`=0, `match_count`=0, `rec_valid`=0. The next match yields {1,0}.
- Drive `reset` low for 1 cycle with 3 records queued → all outputs 0 immediately. A post-release match yields {1,0} with `match_count`=1.

Source files
------------

// File: rtl/snail_match_logger.sv
// Match logger: counts detector pulses, measures inter-match gaps and
// queues {first, gap} records in a circular FIFO drained by valid/ready.
// Ports: clk, reset (async, active-low), match, clear (sync)
//        rec_valid/rec_ready/rec_first/rec_gap  head record handshake
//        match_count, overflow (sticky), level  status
module snail_match_logger #(
  parameter int GAP_W = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     match,
  input  logic                     clear,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic                     rec_first,
  output logic [GAP_W-1:0]         rec_gap,
  output logic [CNT_W-1:0]         match_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [GAP_W-1:0] GMAX = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic             mem_first_q [DEPTH];
  logic [GAP_W-1:0] mem_gap_q   [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [GAP_W-1:0] dist_q, dist_d;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic             ovf_q;

  logic             pop, push, full;
  logic             new_first;
  logic [GAP_W-1:0] new_gap;

  always_comb begin
    full      = (lvl_q == FULL);
    pop       = rec_valid && rec_ready;
    // A full FIFO still accepts a record when the head leaves this cycle
    push      = match && (!full || pop);
    new_first = armed_q;
    new_gap   = armed_q ? '0 : dist_q;
    lvl_d     = lvl_q + LW'(push) - LW'(pop);
    dist_d    = dist_q;
    if (match)
      dist_d = GAP_W'(1);
    else if (dist_q != GMAX)
      dist_d = dist_q + GAP_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      dist_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_first_q[i] <= 1'b0;
        mem_gap_q[i]   <= '0;
      end
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      dist_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      dist_q <= dist_d;
      lvl_q  <= lvl_d;
      if (match) begin
        armed_q <= 1'b0;
        if (cnt_q != CMAX)
          cnt_q <= cnt_q + CNT_W'(1);
        if (!push)
          ovf_q <= 1'b1;
      end
      if (push) begin
        mem_first_q[wr_q] <= new_first;
        mem_gap_q[wr_q]   <= new_gap;
        wr_q              <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
    end
  end

  assign rec_valid   = (lvl_q != '0);
  assign rec_first   = mem_first_q[rd_q];
  assign rec_gap     = mem_gap_q[rd_q];
  assign match_count = cnt_q;
  assign overflow    = ovf_q;
  assign level       = lvl_q;

endmodule

// File: tb/tb_snail_match_logger.sv
// Bench for snail_match_logger: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_snail_match_logger;

  localparam int GAP_W = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int GMAX  = 255;

  logic             clk = 0;
  logic             reset = 0;
  logic             match = 0;
  logic             clear = 0;
  logic             rec_ready = 0;
  logic             rec_valid;
  logic             rec_first;
  logic [GAP_W-1:0] rec_gap;
  logic [CNT_W-1:0] match_count;
  logic             overflow;
  logic [2:0]       level;

  snail_match_logger #(
    .GAP_W(GAP_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .match(match), .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_first(rec_first), .rec_gap(rec_gap),
    .match_count(match_count), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_first[$];
  int m_gap[$];
  int m_cnt;
  int m_ovf;
  int m_armed;
  int m_last;
  int cyc;

  // records accepted by the consumer, as seen on the DUT head
  int log_first[$];
  int log_gap[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_first.delete();
    m_gap.delete();
    m_cnt   = 0;
    m_ovf   = 0;
    m_armed = 1;
    m_last  = 0;
  endtask

  task automatic compare();
    chk("level", int'(level), m_first.size());
    chk("rec_valid", int'(rec_valid), int'(m_first.size() != 0));
    chk("match_count", int'(match_count), m_cnt);
    chk("overflow", int'(overflow), m_ovf);
    if (m_first.size() != 0) begin
      chk("rec_first", int'(rec_first), m_first[0]);
      chk("rec_gap", int'(rec_gap), m_gap[0]);
    end
  endtask

  // One clock: log accepted head, advance model, then compare.
  task automatic tick();
    bit pop, full, push;
    int g;
    if (reset && !clear && rec_valid && rec_ready) begin
      log_first.push_back(int'(rec_first));
      log_gap.push_back(int'(rec_gap));
    end
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_reset();
    end else if (clear) begin
      model_reset();
    end else begin
      pop  = (m_first.size() != 0) && rec_ready;
      full = (m_first.size() == DEPTH);
      push = match && (!full || pop);
      if (pop) begin
        void'(m_first.pop_front());
        void'(m_gap.pop_front());
      end
      if (match) begin
        g = cyc - m_last;
        if (g > GMAX) g = GMAX;
        if (m_cnt < 65535) m_cnt++;
        if (!push) m_ovf = 1;
        if (push) begin
          m_first.push_back(m_armed);
          m_gap.push_back(m_armed ? 0 : g);
        end
        m_armed = 0;
        m_last  = cyc;
      end
    end
    #1;
    compare();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    match = 1;
    tick();
    match = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic chk_log(string name, int idx, int f, int g);
    if (log_first.size() <= idx) begin
      chk({name, "_missing"}, log_first.size(), idx + 1);
    end else begin
      chk({name, "_first"}, log_first[idx], f);
      chk({name, "_gap"}, log_gap[idx], g);
    end
  endtask

  initial begin
    model_reset();
    cyc = 0;
    #1;
    chk("rst_valid", int'(rec_valid), 0);
    chk("rst_first", int'(rec_first), 0);
    chk("rst_gap", int'(rec_gap), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_level", int'(level), 0);
    idle(2);
    reset = 1;

    // matches at 10, 13, 20 with consumer always ready
    rec_ready = 1;
    idle(9);
    pulse();
    idle(2);
    pulse();
    idle(6);
    pulse();
    idle(3);
    chk("t1_nlog", log_first.size(), 3);
    chk_log("t1_r0", 0, 1, 0);
    chk_log("t1_r1", 1, 0, 3);
    chk_log("t1_r2", 2, 0, 7);
    chk("t1_count", int'(match_count), 3);
    chk("t1_ovf", int'(overflow), 0);

    // fill with consumer stalled, then drain
    do_clear();
    log_first.delete();
    log_gap.delete();
    rec_ready = 0;
    for (int i = 0; i < 6; i++) begin
      pulse();
      idle(2);
    end
    chk("t2_level", int'(level), 4);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_count", int'(match_count), 6);
    rec_ready = 1;
    idle(4);
    chk("t2_level_end", int'(level), 0);
    chk("t2_nlog", log_first.size(), 4);
    chk_log("t2_r0", 0, 1, 0);
    chk_log("t2_r1", 1, 0, 3);
    chk_log("t2_r2", 2, 0, 3);
    chk_log("t2_r3", 3, 0, 3);

    // gap saturation
    do_clear();
    log_first.delete();
    log_gap.delete();
    pulse();
    idle(299);
    pulse();
    idle(2);
    chk_log("t3_r1", 1, 0, 255);

    // full FIFO with simultaneous match and pop
    do_clear();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      pulse();
      idle(2);
    end
    chk("t4_full", int'(level), 4);
    rec_ready = 1;
    pulse();
    rec_ready = 0;
    chk("t4_level", int'(level), 4);
    chk("t4_ovf", int'(overflow), 0);
    log_first.delete();
    log_gap.delete();
    rec_ready = 1;
    idle(4);
    chk_log("t4_tail", 3, 0, 3);

    // clear in the same cycle as match, two records queued
    rec_ready = 0;
    pulse();
    idle(2);
    pulse();
    clear = 1;
    match = 1;
    tick();
    clear = 0;
    match = 0;
    chk("t5_level", int'(level), 0);
    chk("t5_count", int'(match_count), 0);
    chk("t5_valid", int'(rec_valid), 0);
    pulse();
    chk("t5_first", int'(rec_first), 1);
    chk("t5_gap", int'(rec_gap), 0);

    // asynchronous reset with three records queued
    idle(2);
    pulse();
    idle(2);
    pulse();
    chk("t6_pre", int'(level), 3);
    #2;
    reset = 0;
    model_reset();
    #1;
    chk("t6_valid", int'(rec_valid), 0);
    chk("t6_first", int'(rec_first), 0);
    chk("t6_gap", int'(rec_gap), 0);
    chk("t6_count", int'(match_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    chk("t6_level", int'(level), 0);
    tick();
    reset = 1;
    idle(1);
    pulse();
    chk("t6_post_first", int'(rec_first), 1);
    chk("t6_post_gap", int'(rec_gap), 0);
    chk("t6_post_count", int'(match_count), 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
